lsu_stage: RTL and testbench
============================

// Module: lsu_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute unit. Takes the ALU result (address or pass-through
//  value) plus store data, issues at most one data-memory request per instruction via valid/ready, aligns/extends
//  load data, hands result to writeback. Multi-cycle FSM; one instruction in flight; stalls upstream via in_ready.
// PARAMETERS
//  ADDR_W   32  address width (exu_data[ADDR_W-1:0] is the address)
//  DATA_W   32  data width; fixed 32 (4 byte lanes), other values unsupported
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  in_valid        in   1   upstream has an instruction
//  in_ready        out  1   stage can accept (high only in IDLE)
//  exu_data        in   32  execute result: memory address, or value passed through for non-memory ops
//  store_data      in   32  rs2 value for stores
//  lsu_op          in   5   {mem_en, mem_wen, unsigned, size[1:0]}; size 00=B 01=H 10=W 11=W(reserved)
//  mem_req_valid   out  1   memory request pending
//  mem_req_ready   in   1   memory accepts request
//  mem_addr        out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wen         out  1   1=store, 0=load
//  mem_wdata       out  32  lane-replicated store data
//  mem_wmask       out  4   byte enables (0 for loads)
//  mem_resp_valid  in   1   load data valid (one-cycle pulse)
//  mem_rdata       in   32  load data word
//  out_valid       out  1   result ready for writeback
//  out_ready       in   1   writeback accepts result
//  lsu_data        out  32  result: loaded value, pass-through value, or 0 for stores
//  lsu_misalign    out  1   misaligned access flag (only with LSU_MISALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; mem_req_valid=0, out_valid=0; mem_addr/mem_wdata/lsu_data=0; mem_wmask=0; mem_wen=0.
//  Reset mid-operation aborts instruction, no output pulse; memory side shares rst, a late resp_valid is ignored.
//  IDLE: in_ready=1. in_valid&&in_ready: latch exu_data, store_data, lsu_op. mem_en=0 -> DONE with
//   lsu_data=exu_data; mem_en=1 -> REQ.
//  REQ: mem_req_valid=1; addr/wen/wdata/wmask stable until mem_req_ready. On handshake: store -> DONE
//   (lsu_data=0); load -> WAIT. Handshake may occur in the first REQ cycle.
//  WAIT: on mem_resp_valid, select lane by addr[1:0], extend, latch lsu_data, -> DONE.
//   resp_valid outside WAIT is ignored.
//  DONE: out_valid=1, lsu_data stable; on out_ready -> IDLE (next accept one cycle later, no bypass).
//  Latency accept->out_valid: non-mem 1 cycle; store 2 (ready immediate); load 3 (ready + resp next cycle).
//  Store mask: B 4'b0001<<a[1:0]; H 4'b0011<<{a[1],1'b0}; W 4'b1111. wdata: B {4{sd[7:0]}}, H {2{sd[15:0]}}, W sd.
//  Load extract: B rdata byte a[1:0]; H halfword a[1]; W full. unsigned=1 zero-extends, else sign-extends.
//  Mis-aligned without check: H uses a[1] (a[0] ignored), W ignores a[1:0].
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: port lsu_misalign present. H with a[0]=1 or W with a[1:0]!=0 -> no memory
//   request; go IDLE->DONE; lsu_data=0, lsu_misalign=1 for the DONE cycles. Otherwise lsu_misalign=0; reset 0.
//  Undefined: lsu_misalign port absent; misaligned access proceeds as aligned per the lane rules above.
// TESTING
//  Pass-through: op=5'b0_0_0_10, exu_data=0x1234 -> no mem_req_valid; out_valid one cycle later, lsu_data=0x1234.
//  Store byte: exu_data=0x8000_0003, store_data=0xAB, op=5'b1_1_0_00 -> mem_addr=0x8000_0000, wmask=4'b1000,
//   wdata=0xABABABAB; lsu_data=0.
//  Signed/unsigned load: addr 0x8000_0002, rdata=0x80FF_0000, op LH -> lsu_data=0xFFFF_80FF; LHU -> 0x0000_80FF;
//   LB at addr 0x...03 -> 0xFFFF_FF80.
//  Backpressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles -> req fields stable, in_ready=0 throughout,
//   lsu_data held; exactly one write-back handshake.
//  Reset in WAIT: assert rst one cycle, then inject mem_resp_valid -> IDLE, out_valid stays 0, in_ready=1.
//  LSU_MISALIGN_CHECK_EN: LW at 0x8000_0002 -> mem_req_valid never high; out_valid next cycle, lsu_misalign=1, lsu_data=0.

Source files
------------

// File: rtl/lsu_stage.sv
// Memory-access stage: one instruction in flight, issues one data-memory request, aligns/extends load data.
// Optional macro LSU_MISALIGN_CHECK_EN adds the lsu_misalign port and suppresses misaligned requests.
module lsu_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exu_data,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        lsu_op,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] lsu_data
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic              lsu_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        op_q, op_d;
  logic              accept;
  logic              in_misalign;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;

  // op fields: [4]=mem_en [3]=wen [2]=unsigned [1:0]=size
  assign accept = in_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign in_misalign = lsu_op[4] &&
                       (((lsu_op[1:0] == 2'b01) && exu_data[0]) ||
                        (lsu_op[1] && (exu_data[1:0] != 2'b00)));
  assign lsu_misalign = misalign_q;
`else
  assign in_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sd_q    <= '0;
      data_q  <= '0;
      op_q    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      data_q  <= data_d;
      op_q    <= op_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (!lsu_op[4] || in_misalign) ? S_DONE : S_REQ;
      S_REQ:   if (mem_req_ready) state_d = op_q[3] ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q[1:0])
      2'b00:   ld_val = {{24{ld_byte[7] & ~op_q[2]}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~op_q[2]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Memory ops start with a zero result so stores and suppressed accesses report 0.
  always_comb begin
    addr_d = addr_q;
    sd_d   = sd_q;
    op_d   = op_q;
    data_d = data_q;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
    if (state_q == S_DONE && out_ready) misalign_d = 1'b0;
    if (accept) misalign_d = in_misalign;
`endif
    if (accept) begin
      addr_d = exu_data[ADDR_W-1:0];
      sd_d   = store_data;
      op_d   = lsu_op;
      data_d = lsu_op[4] ? '0 : exu_data;
    end
    if (state_q == S_WAIT && mem_resp_valid) data_d = ld_val;
  end

  always_comb begin
    in_ready      = (state_q == S_IDLE);
    mem_req_valid = (state_q == S_REQ);
    out_valid     = (state_q == S_DONE);
    mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wen       = op_q[4] & op_q[3];
    lsu_data      = data_q;
    case (op_q[1:0])
      2'b00: begin
        mem_wdata = {4{sd_q[7:0]}};
        mem_wmask = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem_wdata = {2{sd_q[15:0]}};
        mem_wmask = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        mem_wdata = sd_q;
        mem_wmask = 4'b1111;
      end
    endcase
    if (!mem_wen) mem_wmask = 4'b0000;
  end

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] exu_data = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  lsu_op = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] lsu_data;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        lsu_misalign;
`endif

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exu_data(exu_data), .store_data(store_data), .lsu_op(lsu_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .lsu_data(lsu_data)
`ifdef LSU_MISALIGN_CHECK_EN
    , .lsu_misalign(lsu_misalign)
`endif
  );

  always @(posedge clk) if (out_valid && out_ready) hs_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] exu, sd, rdata;
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] data;
    int          lat;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] exu, input logic [31:0] sd,
                              input logic [31:0] rdata, input logic req, input logic [31:0] addr,
                              input logic wen, input logic [31:0] wdata, input logic [3:0] mask,
                              input logic [31:0] data, input int lat, input logic mis);
    vec_t v;
    v.op = op; v.exu = exu; v.sd = sd; v.rdata = rdata; v.req = req; v.addr = addr;
    v.wen = wen; v.wdata = wdata; v.mask = mask; v.data = data; v.lat = lat; v.mis = mis;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit saw, pend, got;
    @(posedge clk); #1;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1; exu_data = v.exu; store_data = v.sd; lsu_op = v.op; mem_rdata = v.rdata;
    mem_req_ready = 1'b1; out_ready = 1'b1; mem_resp_valid = 1'b0;
    saw = 0; pend = 0; got = 0; lat = 99;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mem_resp_valid = 1'b0;
      if (pend) begin mem_resp_valid = 1'b1; pend = 0; end
      if (mem_req_valid) begin
        if (!saw) begin
          chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
          chk($sformatf("v%0d_wen", idx), 32'(mem_wen), 32'(v.wen));
          chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
          chk($sformatf("v%0d_wmask", idx), 32'(mem_wmask), 32'(v.mask));
        end
        saw = 1;
        if (!v.op[3]) pend = 1;
      end
      if (out_valid) begin
        got = 1;
        lat = c;
        chk($sformatf("v%0d_data", idx), lsu_data, v.data);
`ifdef LSU_MISALIGN_CHECK_EN
        chk($sformatf("v%0d_misalign", idx), 32'(lsu_misalign), 32'(v.mis));
`endif
      end
    end
    mem_resp_valid = 1'b0;
    chk($sformatf("v%0d_req_seen", idx), 32'(saw), 32'(v.req));
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int   hs0;

    vecs[0]  = mk(5'b00010, 32'h0000_1234, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0000_1234, 1, 0);
    vecs[1]  = mk(5'b11000, 32'h8000_0003, 32'hAB, 32'h0, 1, 32'h8000_0000, 1, 32'hABAB_ABAB, 4'b1000, 32'h0, 2, 0);
    vecs[2]  = mk(5'b11001, 32'h8000_0002, 32'h1234_CAFE, 32'h0, 1, 32'h8000_0000, 1, 32'hCAFE_CAFE, 4'b1100, 32'h0, 2, 0);
    vecs[3]  = mk(5'b11010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1, 32'h1000_0004, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 2, 0);
    vecs[4]  = mk(5'b10001, 32'h8000_0002, 32'h0, 32'h80FF_0000, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'hFFFF_80FF, 3, 0);
    vecs[5]  = mk(5'b10101, 32'h8000_0002, 32'h0, 32'h80FF_0000, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h0000_80FF, 3, 0);
    vecs[6]  = mk(5'b10000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'hFFFF_FF80, 3, 0);
    vecs[7]  = mk(5'b10100, 32'h8000_0001, 32'h0, 32'h1234_5678, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h0000_0056, 3, 0);
    vecs[8]  = mk(5'b10010, 32'h2000_0008, 32'h0, 32'hCAFE_F00D, 1, 32'h2000_0008, 0, 32'h0, 4'h0, 32'hCAFE_F00D, 3, 0);
    vecs[9]  = mk(5'b00000, 32'hFFFF_FFFF, 32'h55, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[10] = mk(5'b10001, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    vecs[11] = mk(5'b10010, 32'h8000_0002, 32'h0, 32'h80FF_0000, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 1);
`else
    vecs[10] = mk(5'b10001, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'hFFFF_80FF, 3, 0);
    vecs[11] = mk(5'b10010, 32'h8000_0002, 32'h0, 32'h80FF_0000, 1, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h80FF_0000, 3, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_lsu_data", lsu_data, 32'd0);

    // A response pulse while idle must not produce a result.
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("idle_resp_out_valid", 32'(out_valid), 32'd0);
    chk("idle_resp_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure on both the request and the write-back side.
    @(posedge clk); #1;
    hs0 = hs_cnt;
    in_valid = 1'b1; exu_data = 32'h0000_0046; lsu_op = 5'b10001; store_data = 32'h0;
    mem_req_ready = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_req_valid%0d", k), 32'(mem_req_valid), 32'd1);
      chk($sformatf("bp_addr%0d", k), mem_addr, 32'h0000_0044);
      chk($sformatf("bp_wmask%0d", k), 32'(mem_wmask), 32'd0);
      chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("bp_req_dropped", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h8123_4567;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp_out_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", k), lsu_data, 32'hFFFF_8123);
      chk($sformatf("bp_in_ready_done%0d", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_idle", 32'(in_ready), 32'd1);
    chk("bp_out_cleared", 32'(out_valid), 32'd0);
    chk("bp_handshakes", 32'(hs_cnt - hs0), 32'd1);

    // Reset while waiting for load data; the late response is dropped.
    in_valid = 1'b1; exu_data = 32'h8000_0003; lsu_op = 5'b10000; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rw_in_req", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    chk("rw_in_wait", 32'(mem_req_valid | out_valid | in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h8000_0000;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("rw_out_valid", 32'(out_valid), 32'd0);
    chk("rw_in_ready", 32'(in_ready), 32'd1);
    chk("rw_lsu_data", lsu_data, 32'd0);
    @(posedge clk); #1;
    chk("rw_out_valid_later", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
